// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default flit width, input port indices
// and the number of input directions feeding each output allocator.
package noc_pkg;

  localparam int DATASIZE_DEF = 40;
  localparam int WIDTH_DEF    = 3;
  localparam int NUM_IN       = 4;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_W = 2;
  localparam int PORT_L = 3;

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way combinational round-robin arbiter. ptr names the highest
// priority requester; the search proceeds ptr, ptr+1, ... modulo 4 and
// the first active request receives a one-hot grant.
module rr_arbiter_4
  import noc_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic [1:0]        ptr,
  output logic [NUM_IN-1:0] gnt
);

  logic [1:0] idx;
  logic       found;

  // Rotating priority search starting at ptr
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_port_arb.sv
// Output-port allocator for one router output direction. Selects one of
// the N/S/W/L FIFO heads routed to this port, pops it, and registers the
// flit onto the link towards the next router.
// Optional build macro: PRESSURE_PRIO_EN -- prefer the candidate with the
// highest FIFO occupancy; round robin from ptr only breaks ties.
module out_port_arb
  import noc_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int WIDTH    = WIDTH_DEF
) (
  input  logic                fifo_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] N_data_in,
  input  logic [DATASIZE-1:0] S_data_in,
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic                N_valid_in,
  input  logic                S_valid_in,
  input  logic                W_valid_in,
  input  logic                L_valid_in,
  input  logic                N_req_in,
  input  logic                S_req_in,
  input  logic                W_req_in,
  input  logic                L_req_in,
  input  logic [WIDTH:0]      N_pressure_in,
  input  logic [WIDTH:0]      S_pressure_in,
  input  logic [WIDTH:0]      W_pressure_in,
  input  logic [WIDTH:0]      L_pressure_in,
  output logic                fifo_ready_N,
  output logic                fifo_ready_S,
  output logic                fifo_ready_W,
  output logic                fifo_ready_L,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                down_full
);

  logic [NUM_IN-1:0][DATASIZE-1:0] data_a;
  logic [NUM_IN-1:0]               cand;
  logic [NUM_IN-1:0]               prio_req;
  logic [NUM_IN-1:0]               arb_req;
  logic [NUM_IN-1:0]               gnt;
  logic [1:0]                      ptr;
  logic [1:0]                      gnt_idx;
  logic                            ld;
  logic [DATASIZE-1:0]             data_p1;
  logic                            vld_p1;

  assign data_a[PORT_N] = N_data_in;
  assign data_a[PORT_S] = S_data_in;
  assign data_a[PORT_W] = W_data_in;
  assign data_a[PORT_L] = L_data_in;

  assign cand[PORT_N] = N_valid_in && N_req_in;
  assign cand[PORT_S] = S_valid_in && S_req_in;
  assign cand[PORT_W] = W_valid_in && W_req_in;
  assign cand[PORT_L] = L_valid_in && L_req_in;

  // The output register may take a new flit when empty or draining this cycle.
  assign ld = !vld_p1 || !down_full;

`ifdef PRESSURE_PRIO_EN
  logic [NUM_IN-1:0][WIDTH:0] press_a;
  logic [WIDTH:0]             max_p;

  assign press_a[PORT_N] = N_pressure_in;
  assign press_a[PORT_S] = S_pressure_in;
  assign press_a[PORT_W] = W_pressure_in;
  assign press_a[PORT_L] = L_pressure_in;

  // Keep only candidates at the highest occupancy; the RR arbiter breaks ties.
  always_comb begin
    max_p    = '0;
    prio_req = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (cand[i] && (press_a[i] > max_p)) max_p = press_a[i];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      prio_req[i] = cand[i] && (press_a[i] == max_p);
    end
  end
`else
  logic unused_pressure;

  assign unused_pressure = ^{N_pressure_in, S_pressure_in, W_pressure_in, L_pressure_in};
  assign prio_req        = cand;
`endif

  assign arb_req = ld ? prio_req : '0;

  rr_arbiter_4 u_rr (
    .req (arb_req),
    .ptr (ptr),
    .gnt (gnt)
  );

  // One-hot grant to index, used both for the data mux and the pointer update.
  always_comb begin
    gnt_idx = 2'd0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) gnt_idx = 2'(i);
    end
  end

  // Pops are suppressed while reset is held so no FIFO loses a flit.
  assign fifo_ready_N = gnt[PORT_N] && rst_n;
  assign fifo_ready_S = gnt[PORT_S] && rst_n;
  assign fifo_ready_W = gnt[PORT_W] && rst_n;
  assign fifo_ready_L = gnt[PORT_L] && rst_n;

  // ---- stage p1: link output register and round-robin pointer ----
  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      ptr     <= 2'd0;
    end else if (ld) begin
      if (|gnt) begin
        data_p1 <= data_a[gnt_idx];
        vld_p1  <= 1'b1;
        ptr     <= gnt_idx + 2'd1;
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_out_port_arb.sv
// Directed self-checking bench for out_port_arb.
module tb_out_port_arb;

  localparam int DS = 40;
  localparam int WD = 3;

  logic          clk;
  logic          rst_n;
  logic [DS-1:0] d [4];
  logic          v [4];
  logic          r [4];
  logic [WD:0]   p [4];
  logic          down_full;
  logic          fifo_ready_N, fifo_ready_S, fifo_ready_W, fifo_ready_L;
  logic [DS-1:0] out_data;
  logic          out_valid;
  logic [3:0]    rdy;

  int errors = 0;
  int checks = 0;

  assign rdy = {fifo_ready_L, fifo_ready_W, fifo_ready_S, fifo_ready_N};

  out_port_arb #(.DATASIZE(DS), .WIDTH(WD)) dut (
    .fifo_clk      (clk),
    .rst_n         (rst_n),
    .N_data_in     (d[0]),
    .S_data_in     (d[1]),
    .W_data_in     (d[2]),
    .L_data_in     (d[3]),
    .N_valid_in    (v[0]),
    .S_valid_in    (v[1]),
    .W_valid_in    (v[2]),
    .L_valid_in    (v[3]),
    .N_req_in      (r[0]),
    .S_req_in      (r[1]),
    .W_req_in      (r[2]),
    .L_req_in      (r[3]),
    .N_pressure_in (p[0]),
    .S_pressure_in (p[1]),
    .W_pressure_in (p[2]),
    .L_pressure_in (p[3]),
    .fifo_ready_N  (fifo_ready_N),
    .fifo_ready_S  (fifo_ready_S),
    .fifo_ready_W  (fifo_ready_W),
    .fifo_ready_L  (fifo_ready_L),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .down_full     (down_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0;
      r[i] = 1'b0;
      p[i] = '0;
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    down_full = 1'b0;
    d[0] = 40'h11; d[1] = 40'h22; d[2] = 40'h33; d[3] = 40'h44;
    clear_in();
    #1 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_ready",     64'(rdy),       64'd0);

    // Single flit from N
    d[0] = 40'hAA; v[0] = 1'b1; r[0] = 1'b1;
    #1 chk("single_ready", 64'(rdy), 64'b0001);
    step();
    clear_in();
    #1;
    chk("single_data",  64'(out_data),  64'hAA);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_ready_off", 64'(rdy), 64'd0);
    step();
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_data_hold", 64'(out_data), 64'hAA);

    // Restore ptr to N, then all four requesting continuously
    reset_pulse();
    d[0] = 40'h11;
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b1;
      r[i] = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("rr_ready_%0d", k), 64'(rdy), 64'(4'b0001 << (k % 4)));
      step();
      chk($sformatf("rr_data_%0d", k), 64'(out_data), 64'h11 * 64'((k % 4) + 1));
      chk($sformatf("rr_valid_%0d", k), 64'(out_valid), 64'd1);
    end

    // Downstream stall for three cycles, then release
    down_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall_ready_%0d", k), 64'(rdy), 64'd0);
      step();
      chk($sformatf("stall_data_%0d", k), 64'(out_data), 64'h11);
      chk($sformatf("stall_valid_%0d", k), 64'(out_valid), 64'd1);
    end
    down_full = 1'b0;
    #1 chk("release_ready", 64'(rdy), 64'b0010);
    step();
    chk("release_data", 64'(out_data), 64'h22);

    // Asynchronous reset in the middle of a stall
    clear_in();
    v[0] = 1'b1; r[0] = 1'b1;
    down_full = 1'b1;
    #1 chk("prerst_ready", 64'(rdy), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data",  64'(out_data),  64'd0);
    chk("midrst_ready", 64'(rdy),       64'd0);
    step();
    chk("holdrst_ready", 64'(rdy), 64'd0);
    chk("holdrst_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    down_full = 1'b0;
    clear_in();

    // Non-candidates ignored; L granted, pointer wraps to N
    v[2] = 1'b1; r[2] = 1'b0;
    v[1] = 1'b0; r[1] = 1'b1;
    v[3] = 1'b1; r[3] = 1'b1;
    #1 chk("lonly_ready", 64'(rdy), 64'b1000);
    step();
    chk("lonly_data", 64'(out_data), 64'h44);
    clear_in();
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);
    down_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b1;
      r[i] = 1'b1;
    end
    #1 chk("wrap_full_empty_ready", 64'(rdy), 64'b0001);
    step();
    chk("wrap_data",  64'(out_data),  64'h11);
    chk("wrap_valid", 64'(out_valid), 64'd1);
    clear_in();
    down_full = 1'b0;

`ifdef PRESSURE_PRIO_EN
    reset_pulse();
    v[0] = 1'b1; r[0] = 1'b1; p[0] = 4'd2;
    v[1] = 1'b1; r[1] = 1'b1; p[1] = 4'd5;
    #1 chk("press_ready", 64'(rdy), 64'b0010);
    step();
    chk("press_data", 64'(out_data), 64'h22);
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b1;
      r[i] = 1'b1;
      p[i] = 4'd3;
    end
    #1 chk("press_tie_ready", 64'(rdy), 64'b0100);
    step();
    chk("press_tie_data", 64'(out_data), 64'h33);
    clear_in();
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
